// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access using a req/ack handshake with variable wait states.
// Data requests take priority over fetch. The optional access timeout is
// enabled by defining MEM_TIMEOUT_EN; in the default build accesses wait
// indefinitely and bus_err is tied low.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_o,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

    logic [CNT_W-1:0] wait_cnt;
`else
    // Timeout configuration is meaningless without the feature.
    logic unused_cfg;
    assign unused_cfg = ^{32'(MAX_WAIT), NOP_INSTR};
    assign bus_err    = 1'b0;
`endif

    // Hold the pipeline while a request is outstanding; release in the valid cycle.
    assign stall_o = (if_req & ~if_valid) | (d_req & ~d_valid);

    // Arbitration FSM with registered memory-side and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
`endif
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    // Data is the older instruction, so it always wins.
                    if (d_req) begin
                        state     <= DATA;
                        mem_req   <= 1'b1;
                        mem_wen   <= d_wen;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else if (if_req) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_wen  <= 1'b0;
                        mem_addr <= if_addr;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                FETCH, DATA: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_wen <= 1'b0;
                        if (state == FETCH) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            d_rdata <= mem_wen ? '0 : mem_rdata;
                            d_valid <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        // Give up: complete with a harmless result and flag the error.
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_wen <= 1'b0;
                        bus_err <= 1'b1;
                        if (state == FETCH) begin
                            if_rdata <= NOP_INSTR;
                            if_valid <= 1'b1;
                        end else begin
                            d_rdata <= '0;
                            d_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    // Requests seen here belong to the access just completed.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written sequences for back-to-back fetches and (when MEM_TIMEOUT_EN
// is defined) the access timeout.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NV = 27;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_o;
    logic          bus_err;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic          rst_n;
        logic          if_req;
        logic [31:0]   if_addr;
        logic          d_req;
        logic          d_wen;
        logic [31:0]   d_addr;
        logic [31:0]   d_wdata;
        logic [31:0]   mem_rdata;
        logic          mem_ack;
        logic          e_req;
        logic          e_wen;
        logic [31:0]   e_addr;
        logic [31:0]   e_wdata;
        logic          e_ifv;
        logic [31:0]   e_ifd;
        logic          e_dv;
        logic [31:0]   e_dd;
        logic          e_stall;
    } vec_t;

    vec_t vecs [NV];

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_o   (stall_o),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", what, got, exp);
        end
    endtask

    task automatic set_idle();
        rst_n     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_wen     = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        // Each row: inputs driven during a cycle, and the outputs expected in that
        // same cycle (registered values from earlier edges, stall_o from these inputs).
        //            rst if  if_addr       d  wen d_addr        d_wdata       mem_rdata     ack  req wen mem_addr      mem_wdata     ifv if_rdata      dv  d_rdata       stall
        vecs[0]  = '{1'b0,1'b1,32'h0000_0100,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[1]  = '{1'b0,1'b1,32'h0000_0100,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[2]  = '{1'b0,1'b1,32'h0000_0100,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[3]  = '{1'b1,1'b1,32'h0000_0100,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[4]  = '{1'b1,1'b1,32'h0000_0100,1'b0,1'b0,32'h0,        32'h0,        32'h0050_0093,1'b1, 1'b1,1'b0,32'h0000_0100,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[5]  = '{1'b1,1'b1,32'h0000_0100,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h0050_0093,1'b0,32'h0,        1'b0};
        vecs[6]  = '{1'b1,1'b1,32'h0000_0104,1'b1,1'b1,32'h0000_2000,32'hDEAD_BEEF,32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[7]  = '{1'b1,1'b1,32'h0000_0104,1'b1,1'b1,32'h0000_2000,32'hDEAD_BEEF,32'hFFFF_FFFF,1'b1, 1'b1,1'b1,32'h0000_2000,32'hDEAD_BEEF,1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[8]  = '{1'b1,1'b1,32'h0000_0104,1'b1,1'b1,32'h0000_2000,32'hDEAD_BEEF,32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b1,32'h0,        1'b1};
        vecs[9]  = '{1'b1,1'b1,32'h0000_0104,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[10] = '{1'b1,1'b1,32'h0000_0104,1'b0,1'b0,32'h0,        32'h0,        32'h00A0_0113,1'b1, 1'b1,1'b0,32'h0000_0104,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[11] = '{1'b1,1'b1,32'h0000_0104,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h00A0_0113,1'b0,32'h0,        1'b0};
        vecs[12] = '{1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0000_3000,32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[13] = '{1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0000_3000,32'h0,        32'h0,        1'b0, 1'b1,1'b0,32'h0000_3000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[14] = '{1'b1,1'b0,32'h0,        1'b1,1'b1,32'h0000_5550,32'h0000_0077,32'h0,        1'b0, 1'b1,1'b0,32'h0000_3000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[15] = '{1'b1,1'b1,32'h0000_0600,1'b1,1'b0,32'h0000_3000,32'h0,        32'h0,        1'b0, 1'b1,1'b0,32'h0000_3000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[16] = '{1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0000_3000,32'h0,        32'h0,        1'b0, 1'b1,1'b0,32'h0000_3000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[17] = '{1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0000_3000,32'h0,        32'h1234_5678,1'b1, 1'b1,1'b0,32'h0000_3000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[18] = '{1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0000_3000,32'h0,        32'hBBBB_BBBB,1'b1, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b1,32'h1234_5678,1'b0};
        vecs[19] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        32'hAAAA_AAAA,1'b1, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
        vecs[20] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
        vecs[21] = '{1'b1,1'b1,32'h0000_0300,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[22] = '{1'b1,1'b1,32'h0000_0300,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b1,1'b0,32'h0000_0300,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[23] = '{1'b1,1'b1,32'h0000_0300,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b1,1'b0,32'h0000_0300,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[24] = '{1'b0,1'b1,32'h0000_0300,1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b1,1'b0,32'h0000_0300,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1};
        vecs[25] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        32'hCCCC_CCCC,1'b1, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
        vecs[26] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};

        // Put the design into a known state before the first checked row.
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < int'(NV); i++) begin
            bit ok;
            @(negedge clk);
            rst_n     = vecs[i].rst_n;
            if_req    = vecs[i].if_req;
            if_addr   = vecs[i].if_addr;
            d_req     = vecs[i].d_req;
            d_wen     = vecs[i].d_wen;
            d_addr    = vecs[i].d_addr;
            d_wdata   = vecs[i].d_wdata;
            mem_rdata = vecs[i].mem_rdata;
            mem_ack   = vecs[i].mem_ack;
            #1;
            ok = (mem_req === vecs[i].e_req) && (if_valid === vecs[i].e_ifv) &&
                 (d_valid === vecs[i].e_dv) && (stall_o === vecs[i].e_stall) &&
                 (bus_err === 1'b0) &&
                 (!vecs[i].e_req || ((mem_wen === vecs[i].e_wen) &&
                                     (mem_addr === vecs[i].e_addr) &&
                                     (!vecs[i].e_wen || (mem_wdata === vecs[i].e_wdata)))) &&
                 (!vecs[i].e_ifv || (if_rdata === vecs[i].e_ifd)) &&
                 (!vecs[i].e_dv || (d_rdata === vecs[i].e_dd));
            n_vec++;
            if (!ok) begin
                n_miss++;
                $display("FAIL vec%0d: got req=%b wen=%b addr=%h wdata=%h ifv=%b ifd=%h dv=%b dd=%h stall=%b berr=%b; required req=%b wen=%b addr=%h wdata=%h ifv=%b ifd=%h dv=%b dd=%h stall=%b berr=0",
                         i, mem_req, mem_wen, mem_addr, mem_wdata, if_valid, if_rdata,
                         d_valid, d_rdata, stall_o, bus_err,
                         vecs[i].e_req, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_wdata,
                         vecs[i].e_ifv, vecs[i].e_ifd, vecs[i].e_dv, vecs[i].e_dd,
                         vecs[i].e_stall);
            end
        end

        // Back-to-back fetches with an always-ready memory: valid every 3 cycles.
        begin : b2b_seq
            int last;
            int pulses;
            set_idle();
            @(negedge clk);
            if_req  = 1'b1;
            if_addr = 32'h0000_0500;
            last    = -1;
            pulses  = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                mem_ack   = mem_req;
                mem_rdata = 32'h0000_0013 + 32'(c);
                #1;
                if (mem_req)
                    chk(mem_addr === 32'h0000_0500, "b2b_addr", mem_addr, 32'h0000_0500);
                chk(!(if_valid && d_valid), "b2b_one_valid", {30'h0, if_valid, d_valid}, 32'h0);
                if (if_valid) begin
                    chk(if_rdata === 32'h0000_0013 + 32'(c - 1), "b2b_rdata",
                        if_rdata, 32'h0000_0013 + 32'(c - 1));
                    if (last >= 0)
                        chk(c - last == 3, "b2b_spacing", 32'(c - last), 32'd3);
                    last = c;
                    pulses++;
                end
            end
            chk(pulses == 4, "b2b_pulses", 32'(pulses), 32'd4);
            set_idle();
            repeat (2) @(negedge clk);
        end

`ifdef MEM_TIMEOUT_EN
        // Unanswered fetch times out with a NOP; the error stays until reset.
        begin : timeout_seq
            int  c;
            bit  seen;
            @(negedge clk);
            if_req  = 1'b1;
            if_addr = 32'h0000_0400;
            c       = 0;
            seen    = 1'b0;
            while (!seen && c < 40) begin
                @(negedge clk);
                c++;
                #1;
                if (if_valid) seen = 1'b1;
            end
            chk(seen && c == 16, "timeout_latency", 32'(c), 32'd16);
            chk(if_rdata === 32'h0000_0013, "timeout_nop", if_rdata, 32'h0000_0013);
            chk(bus_err === 1'b1, "timeout_err", 32'(bus_err), 32'd1);
            if_req = 1'b0;
            @(negedge clk);
            d_req  = 1'b1;
            d_wen  = 1'b0;
            d_addr = 32'h0000_0010;
            seen   = 1'b0;
            c      = 0;
            while (!seen && c < 10) begin
                @(negedge clk);
                mem_ack   = mem_req;
                mem_rdata = 32'h0000_5A5A;
                c++;
                #1;
                if (d_valid) seen = 1'b1;
            end
            chk(seen && d_rdata === 32'h0000_5A5A, "after_err_load", d_rdata, 32'h0000_5A5A);
            chk(bus_err === 1'b1, "err_sticky", 32'(bus_err), 32'd1);
            set_idle();
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk(bus_err === 1'b0, "err_cleared", 32'(bus_err), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the instruction-fetch side and the data-memory side of the 5-stage RV32I core.
- Sequences each access with a req/ack memory handshake that supports variable wait states.
- Returns read data with a one-cycle valid pulse.
- Exports a pipeline-hold signal so the core freezes all stage registers while an access is outstanding.

Parameters:
ADDR_W, 32, byte address width on all ports
DATA_W, 32, data width on all ports
MAX_WAIT, 15, wait cycles before timeout; used only when MEM_TIMEOUT_EN is defined
NOP_INSTR, 32'h0000_0013, instruction returned on a fetch timeout (addi x0,x0,0)

Ports:
clk  in  1  core clock; all state changes on posedge
rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; held high until if_valid is seen
if_addr  in  ADDR_W  fetch address (pcF)
if_rdata  out  DATA_W  registered instruction word
if_valid  out  1  one-cycle pulse: if_rdata is valid
d_req  in  1  data request; held high until d_valid is seen
d_wen  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address (ALU result, M stage)
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  registered load data
d_valid  out  1  one-cycle pulse: data access completed
mem_req  out  1  memory request
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1
mem_ack  in  1  memory completion; one cycle
stall_o  out  1  pipeline hold = (if_req & ~if_valid) | (d_req & ~d_valid)
bus_err  out  1  sticky timeout flag; 0 when feature is compiled out

Behaviour:
- Reset is synchronous, active-low, clk-only. While rst_n=0:
  - state <= IDLE
  - mem_req, mem_wen, if_valid, d_valid, bus_err <= 0
  - if_rdata, d_rdata, mem_addr, mem_wdata <= 0
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE:
  - d_req=1 -> DATA. Latch d_addr, d_wen, d_wdata into mem_addr, mem_wen, mem_wdata.
  - else if_req=1 -> FETCH. Latch if_addr; mem_wen=0.
  - Data has fixed priority: it is the older instruction, and the pipeline is stalled, so fetch cannot starve.
- FETCH/DATA:
  - mem_req=1 registered; address, wen and wdata are held stable until mem_ack.
  - When mem_ack=1: capture mem_rdata into if_rdata (FETCH) or d_rdata (DATA); d_rdata=0 for stores. Go to RESP, and drop mem_req at the same edge.
  - Changes on req/addr inputs during these states are ignored.
- RESP:
  - Exactly one of if_valid/d_valid is high for one cycle.
  - Requests sampled in RESP are not new requests; the pipeline advances on this edge. Go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> mem_req high at cycle 1.
  - Zero-wait ack at cycle 1 -> valid at cycle 2.
  - Each wait cycle adds one cycle.
  - Back-to-back accesses have 3 cycles minimum spacing (IDLE, ACCESS, RESP).
- Simultaneous if_req and d_req in IDLE: data first. Fetch is served on the next IDLE if still asserted.
- mem_ack in IDLE or RESP: ignored; no state change, no valid.
- rst_n low mid-access: mem_req=0 after the reset edge; the outstanding access is abandoned and a late ack is ignored.
- stall_o is combinational. It is low in the valid cycle so the stage registers advance exactly once.
- if_valid and d_valid are never high together.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A 4-bit+ counter clears on entry to FETCH/DATA and increments each cycle without mem_ack.
  - When the count reaches MAX_WAIT: drop mem_req, go to RESP, and return NOP_INSTR (fetch) or 0 (data) with the normal valid pulse.
  - bus_err is set and stays set until reset.
  - An ack arriving in the same cycle as expiry wins: normal completion, no error.
- Undefined: no counter; waits indefinitely; bus_err tied 0.

Test Plan:
- Reset: hold rst_n=0 3 cycles with if_req=1 -> mem_req=0, if_valid=0, stall_o=1. Release; mem_req=1 one cycle later with mem_addr=if_addr.
- Zero-wait fetch: if_addr=0x0000_0100, ack at the first mem_req cycle with mem_rdata=0x0050_0093 -> if_valid pulse 2 cycles after the request, if_rdata=0x0050_0093, stall_o low only in that cycle.
- Collision: if_req and d_req (store, addr 0x2000, wdata 0xDEAD_BEEF) both rise in IDLE -> first access is mem_wen=1 to 0x2000 with d_valid; the fetch follows, with mem_req high 2 cycles after d_valid.
- Wait states: load from 0x3000, ack after 4 wait cycles, mem_rdata=0x1234_5678 -> mem_addr stable 5 cycles, d_valid on the cycle after ack, d_rdata=0x1234_5678.
- Spurious/reset: ack pulse in IDLE -> no valid. rst_n=0 during a 3-cycle wait -> mem_req=0 next cycle; late ack ignored.
- MEM_TIMEOUT_EN, MAX_WAIT=15, no ack -> after 15 cycles if_valid=1 with if_rdata=0x0000_0013 and bus_err=1, held across later successful accesses until rst_n=0.
